dual_mem_arbiter: RTL and testbench
===================================

# dual_mem_arbiter

Shares the single unified RAM port between the two pipelined cores; each core has an instruction fetch port and a data port. The block runs a small access FSM and grants requests round-robin across cores, with data before instruction inside a core. It also holds the LL/SC reservation state for both cores. It sits between the two cores' cache/memory interfaces and the RAM model, in the same role the control unit plays for one pipeline: it sequences a shared datapath resource.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- WORD_W, 32, data word width

Ports:
- CLK  in  1  system clock. Everything is rising-edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  2  instruction read request, one bit per core (bit c = core c).
- iaddr  in  2×ADDR_W  instruction address per core.
- iwait  out  2  high while core c's instruction request is not yet served.
- iload  out  2×WORD_W  fetched instruction. Valid only in the cycle iwait[c] is low.
- dREN  in  2  data read request per core.
- dWEN  in  2  data write request per core. dREN and dWEN are never both high for one core.
- datomic  in  2  qualifies the data request: with dREN it is LL, with dWEN it is SC.
- daddr  in  2×ADDR_W  data address per core.
- dstore  in  2×WORD_W  store data per core.
- dwait  out  2  high while core c's data request is not yet served.
- dload  out  2×WORD_W  load data, or the SC result (1 = success, 0 = fail). Valid only in the cycle dwait[c] is low.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data. Valid when ram_ready is high.
- ram_ready  in  1  RAM access complete, sampled while a strobe is asserted.

## Operation
- The FSM has three states: IDLE, BUSY and RESP.
- **IDLE**
  - Builds a candidate for each core: the data request if dREN|dWEN, otherwise the instruction request if iREN, otherwise none.
  - If both cores have a candidate, the core selected is the one that is not last_core. If only one core has a candidate, that core is selected.
  - Registers grant_core, grant_is_data, kind (read, write, LL or SC), address and store data. Sets last_core to grant_core.
  - SC from core c with link_valid[c]=0 or link_addr[c]≠addr[ADDR_W-1:2] is a failing SC. It goes to RESP with no RAM access and a result of 0.
  - Every other grant goes to BUSY.
- **BUSY**
  - Drives ramREN (read or LL) or ramWEN (write or passing SC) continuously, with ramaddr and ramstore taken from the latched values.
  - When ram_ready=1: captures ramload, drops the strobes on the next cycle and goes to RESP.
- **RESP**
  - Drives the granted wait bit low for exactly one cycle. The matching load bus carries the captured data, or 32'd1 for a passing SC, or 32'd0 for a failing SC.
  - Applies the reservation updates listed below, then goes to IDLE.
  - Does not sample new requests.
- All wait bits are combinational: a bit is high whenever its request input is high and the FSM is not in RESP serving that port. A port with no request has its wait bit high.
- Requesters hold their request stable until their wait bit goes low.
- **Reservations**, per core: link_valid and link_addr (word address, addr[ADDR_W-1:2]).
  - LL completion by core c sets link_valid[c]=1 and link_addr[c]=word address.
  - Any SC by core c clears link_valid[c], whether it passes or fails.
  - A completed write (SW or passing SC) by core c to word W clears link_valid[1-c] if link_addr[1-c]==W.
  - A core's own SW does not clear its own reservation.
- Only one access is outstanding at a time. The two RAM strobes are never high in the same cycle.

## Timing
- **Reset:**
  - State IDLE, last_core=1 (core 0 wins the first contention).
  - link_valid=0 for both cores.
  - ramREN=ramWEN=0, ramaddr=0, ramstore=0.
  - iload and dload are 0.
  - iwait and dwait follow their request inputs.
- RST asserted in BUSY or RESP abandons the access. Strobes go low in the cycle after the reset edge, no wait bit goes low, and reservations are cleared.
- **Latency:**
  - Request sampled in IDLE at cycle t. The strobe is high from t+1. If ram_ready arrives at cycle t+1+k, the wait bit is low at t+2+k and the FSM is back in IDLE at t+3+k.
  - Minimum is 3 cycles, from request to the cycle after the wait pulse.
  - A failing SC has the wait bit low at t+1.
- Requests arriving while the FSM is in BUSY or RESP are not sampled until the next IDLE cycle.
- Round-robin alternates strictly under continuous contention. A core with no candidate does not affect last_core.
- ram_ready outside BUSY is ignored.

## Test plan
- **Reset.** Hold RST 2 cycles with all requests high. Required: no strobes; iwait=dwait=2'b11 throughout; first grant after release goes to core 0 data.
- **Single read.** Core 0 dREN to 0x100, RAM ready after 2 cycles returning 0xDEADBEEF. Required: ramREN high for 3 cycles; dwait[0] low for exactly 1 cycle with dload[0]=0xDEADBEEF; total 5 cycles.
- **Contention.** Both cores issue iREN continuously with ram_ready tied high. Required: grants go core0, core1, core0, core1; the pair iwait[0]/iwait[1] is never low in the same cycle. Core 0 with dREN and iREN both high is served data first.
- **LL/SC pass.** Core 1 LL 0x200, then SC 0x200 with dstore=0x5. Required: RAM write of 0x5 to 0x200; dload[1]=1; link_valid[1]=0 afterwards.
- **SC fail by interference.** Core 0 LL 0x300, core 1 SW 0x300, then core 0 SC 0x300. Required: SC causes no ramWEN; dload[0]=0; dwait[0] low one cycle after the SC is sampled.
- **Reset mid-access.** Assert RST in the 2nd BUSY cycle of a write. Required: ramWEN low in the next cycle; dwait never low; a following LL/SC pair still passes.

Source files
------------

// File: rtl/dual_mem_arbiter.sv
// Arbitrates two cores' instruction and data ports onto one RAM port.
// Round-robin across cores, data before instruction, LL/SC reservations per core.
module dual_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            iREN,
  input  logic [2*ADDR_W-1:0]   iaddr,
  output logic [1:0]            iwait,
  output logic [2*WORD_W-1:0]   iload,
  input  logic [1:0]            dREN,
  input  logic [1:0]            dWEN,
  input  logic [1:0]            datomic,
  input  logic [2*ADDR_W-1:0]   daddr,
  input  logic [2*WORD_W-1:0]   dstore,
  output logic [1:0]            dwait,
  output logic [2*WORD_W-1:0]   dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [ADDR_W-1:0]     ramaddr,
  output logic [WORD_W-1:0]     ramstore,
  input  logic [WORD_W-1:0]     ramload,
  input  logic                  ram_ready,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {K_RD = 2'd0, K_WR = 2'd1, K_LL = 2'd2, K_SC = 2'd3} kind_t;

  state_t              state;
  kind_t               kind;
  logic                last_core;
  logic                grant_core;
  logic                grant_is_data;
  logic                sc_pass;
  logic [ADDR_W-1:2]   lat_word;
  logic [1:0]          link_valid;
  logic [ADDR_W-1:2]   link_addr [2];
  logic [WORD_W-1:0]   iload_r [2];
  logic [WORD_W-1:0]   dload_r [2];

  logic [1:0]          has_data;
  logic [1:0]          has_cand;
  logic                sel_core;
  logic                sel_data;
  logic [ADDR_W-1:0]   sel_addr;
  logic [WORD_W-1:0]   sel_store;
  kind_t               sel_kind;
  logic                sc_ok;
  logic                writes_mem;
  logic                in_resp;

  always_comb begin
    has_data  = dREN | dWEN;
    has_cand  = has_data | iREN;
    sel_core  = (has_cand == 2'b11) ? ~last_core : has_cand[1];
    sel_data  = has_data[sel_core];
    if (sel_data)
      sel_addr = sel_core ? daddr[2*ADDR_W-1:ADDR_W] : daddr[ADDR_W-1:0];
    else
      sel_addr = sel_core ? iaddr[2*ADDR_W-1:ADDR_W] : iaddr[ADDR_W-1:0];
    sel_store = sel_core ? dstore[2*WORD_W-1:WORD_W] : dstore[WORD_W-1:0];
    sel_kind  = K_RD;
    if (sel_data) begin
      if (dWEN[sel_core]) sel_kind = datomic[sel_core] ? K_SC : K_WR;
      else                sel_kind = datomic[sel_core] ? K_LL : K_RD;
    end
    sc_ok      = link_valid[sel_core] && (link_addr[sel_core] == sel_addr[ADDR_W-1:2]);
    writes_mem = (kind == K_WR) || ((kind == K_SC) && sc_pass);
    in_resp    = (state == RESP);
  end

  // Wait protocol: a wait bit is low only in the single RESP cycle serving that
  // port; the requester holds its request stable until then and takes the load
  // bus in that same cycle. Idle ports read as waiting.
  assign iwait[0] = ~(in_resp & ~grant_core & ~grant_is_data);
  assign iwait[1] = ~(in_resp &  grant_core & ~grant_is_data);
  assign dwait[0] = ~(in_resp & ~grant_core &  grant_is_data);
  assign dwait[1] = ~(in_resp &  grant_core &  grant_is_data);
  assign iload    = {iload_r[1], iload_r[0]};
  assign dload    = {dload_r[1], dload_r[0]};
  assign fsm_state = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      kind          <= K_RD;
      last_core     <= 1'b1;
      grant_core    <= 1'b0;
      grant_is_data <= 1'b0;
      sc_pass       <= 1'b0;
      lat_word      <= '0;
      link_valid    <= 2'b00;
      link_addr[0]  <= '0;
      link_addr[1]  <= '0;
      iload_r[0]    <= '0;
      iload_r[1]    <= '0;
      dload_r[0]    <= '0;
      dload_r[1]    <= '0;
      ramREN        <= 1'b0;
      ramWEN        <= 1'b0;
      ramaddr       <= '0;
      ramstore      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|has_cand) begin
            grant_core    <= sel_core;
            grant_is_data <= sel_data;
            kind          <= sel_kind;
            lat_word      <= sel_addr[ADDR_W-1:2];
            last_core     <= sel_core;
            if ((sel_kind == K_SC) && !sc_ok) begin
              // Lost reservation: answer 0 without touching RAM.
              sc_pass           <= 1'b0;
              dload_r[sel_core] <= '0;
              state             <= RESP;
            end else begin
              sc_pass  <= (sel_kind == K_SC);
              ramREN   <= (sel_kind == K_RD) || (sel_kind == K_LL);
              ramWEN   <= (sel_kind == K_WR) || (sel_kind == K_SC);
              ramaddr  <= sel_addr;
              ramstore <= sel_store;
              state    <= BUSY;
            end
          end
        end
        BUSY: begin
          if (ram_ready) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            state  <= RESP;
            if (grant_is_data)
              dload_r[grant_core] <= sc_pass ? WORD_W'(1) : ramload;
            else
              iload_r[grant_core] <= ramload;
          end
        end
        RESP: begin
          state <= IDLE;
          if (grant_is_data) begin
            if (kind == K_LL) begin
              link_valid[grant_core] <= 1'b1;
              link_addr[grant_core]  <= lat_word;
            end else if (kind == K_SC) begin
              link_valid[grant_core] <= 1'b0;
            end
            // A completed store breaks the other core's matching reservation.
            if (writes_mem && link_valid[~grant_core] && (link_addr[~grant_core] == lat_word))
              link_valid[~grant_core] <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_mem_arbiter.sv
// Bench for dual_mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_dual_mem_arbiter;

  localparam int AW = 32;
  localparam int WW = 32;
  localparam int RD = 0, WR = 1, LL = 2, SC = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic [1:0]    iREN, iwait, dREN, dWEN, datomic, dwait, fsm_state;
  logic [2*AW-1:0] iaddr, daddr;
  logic [2*WW-1:0] iload, dload, dstore;
  logic          ramREN, ramWEN, ram_ready;
  logic [AW-1:0] ramaddr;
  logic [WW-1:0] ramstore, ramload;

  always #5 CLK = ~CLK;

  dual_mem_arbiter #(.ADDR_W(AW), .WORD_W(WW)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .fsm_state(fsm_state)
  );

  // RAM environment
  logic [31:0] env_mem [256];
  assign ramload = env_mem[ramaddr[9:2]];
  always @(posedge CLK) if (ramWEN === 1'b1 && ram_ready) env_mem[ramaddr[9:2]] <= ramstore;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model
  bit          m_active, m_resp, m_last, m_core, m_isdata, m_scpass, m_ren, m_wen;
  int          m_kind;
  logic [31:0] m_addr, m_raddr, m_rstore;
  bit          m_lv [2];
  logic [29:0] m_la [2];
  logic [31:0] m_mem [256];
  logic [31:0] m_iload [2];
  logic [31:0] m_dload [2];

  task automatic model_edge();
    bit cand [2];
    int c;
    logic [31:0] st;
    if (m_wen && ram_ready) m_mem[m_raddr[9:2]] = m_rstore;
    if (RST) begin
      m_active = 0; m_resp = 0; m_last = 1; m_ren = 0; m_wen = 0;
      m_raddr = 0; m_rstore = 0;
      for (int k = 0; k < 2; k++) begin
        m_lv[k] = 0; m_iload[k] = 0; m_dload[k] = 0;
      end
    end else if (m_resp) begin
      m_resp = 0;
      if (m_isdata) begin
        if (m_kind == LL) begin m_lv[m_core] = 1; m_la[m_core] = m_addr[31:2]; end
        if (m_kind == SC) m_lv[m_core] = 0;
        if ((m_kind == WR || (m_kind == SC && m_scpass)) && m_la[!m_core] == m_addr[31:2])
          m_lv[!m_core] = 0;
      end
    end else if (m_active) begin
      if (ram_ready) begin
        if (!m_isdata) m_iload[m_core] = m_mem[m_addr[9:2]];
        else if (m_kind == SC) m_dload[m_core] = 32'd1;
        else m_dload[m_core] = m_mem[m_addr[9:2]];
        m_active = 0; m_ren = 0; m_wen = 0; m_resp = 1;
      end
    end else begin
      for (int k = 0; k < 2; k++) cand[k] = dREN[k] | dWEN[k] | iREN[k];
      if (cand[0] || cand[1]) begin
        if (cand[0] && cand[1]) c = m_last ? 0 : 1;
        else c = cand[0] ? 0 : 1;
        m_last = c[0]; m_core = c[0];
        m_isdata = dREN[c] | dWEN[c];
        m_kind = RD;
        if (m_isdata) begin
          if (dWEN[c]) m_kind = datomic[c] ? SC : WR;
          else m_kind = datomic[c] ? LL : RD;
        end
        m_addr = m_isdata ? daddr[c*AW +: AW] : iaddr[c*AW +: AW];
        st = dstore[c*WW +: WW];
        if (m_kind == SC && !(m_lv[c] && m_la[c] == m_addr[31:2])) begin
          m_scpass = 0; m_dload[c] = 32'd0; m_resp = 1;
        end else begin
          m_scpass = (m_kind == SC);
          m_active = 1;
          m_ren = (m_kind == RD || m_kind == LL);
          m_wen = !m_ren;
          m_raddr = m_addr; m_rstore = st;
        end
      end
    end
  endtask

  task automatic compare();
    logic [1:0] ew_i, ew_d;
    for (int c = 0; c < 2; c++) begin
      ew_i[c] = !(m_resp && m_core == c && !m_isdata);
      ew_d[c] = !(m_resp && m_core == c && m_isdata);
    end
    check("ramREN", ramREN, m_ren);
    check("ramWEN", ramWEN, m_wen);
    check("strobe_excl", ramREN & ramWEN, 0);
    if (m_ren || m_wen) check("ramaddr", ramaddr, m_raddr);
    if (m_wen) check("ramstore", ramstore, m_rstore);
    check("iwait", iwait, ew_i);
    check("dwait", dwait, ew_d);
    for (int c = 0; c < 2; c++) begin
      if (!ew_i[c]) check("iload", iload[c*WW +: WW], m_iload[c]);
      if (!ew_d[c] && m_kind != WR) check("dload", dload[c*WW +: WW], m_dload[c]);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge CLK);
    #1;
    compare();
  endtask

  task automatic set_data(input int c, input bit ren, input bit wen, input bit at,
                          input logic [31:0] addr, input logic [31:0] st);
    dREN[c] = ren; dWEN[c] = wen; datomic[c] = at;
    daddr[c*AW +: AW] = addr; dstore[c*WW +: WW] = st;
  endtask

  // Issue one data request, wait for its wait pulse, drop it, idle one cycle.
  task automatic do_data(input int c, input bit ren, input bit wen, input bit at,
                         input logic [31:0] addr, input logic [31:0] st,
                         output logic [31:0] load, output bit served, output bit saw_wen);
    served = 0; saw_wen = 0; load = 0;
    set_data(c, ren, wen, at, addr, st);
    for (int i = 0; i < 30 && !served; i++) begin
      cycle();
      if (ramWEN) saw_wen = 1;
      if (dwait[c] == 1'b0) begin served = 1; load = dload[c*WW +: WW]; end
    end
    set_data(c, 0, 0, 0, addr, st);
    cycle();
  endtask

  task automatic do_reset();
    RST = 1; cycle(); RST = 0;
  endtask

  logic [31:0] pool [4];
  logic [31:0] load;
  bit served, saw_wen;
  int ren_cnt, low_cnt, served_idx, ngrant, overlap;
  int order [4];

  initial begin
    pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200; pool[3] = 32'h300;
    for (int i = 0; i < 256; i++) begin env_mem[i] = $urandom; m_mem[i] = env_mem[i]; end
    for (int k = 0; k < 2; k++) m_la[k] = 0;

    // Reset with every request asserted
    RST = 1; iREN = 2'b11; dREN = 2'b11; dWEN = 0; datomic = 0; ram_ready = 0;
    daddr = {32'h200, 32'h100}; iaddr = {32'h304, 32'h300}; dstore = 0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("rst_ren", ramREN, 0);
      check("rst_wen", ramWEN, 0);
      check("rst_iwait", iwait, 2'b11);
      check("rst_dwait", dwait, 2'b11);
    end
    check("rst_iload", iload, 0);
    check("rst_dload", dload, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    RST = 0;
    cycle();
    check("first_grant_ren", ramREN, 1);
    check("first_grant_addr", ramaddr, 32'h100);
    ram_ready = 1;
    cycle();
    check("first_grant_dwait", dwait, 2'b10);
    check("first_grant_iwait", iwait, 2'b11);
    iREN = 0; dREN = 0;
    cycle();

    // Single read with RAM ready on the third strobe cycle
    env_mem[8'h40] = 32'hDEADBEEF; m_mem[8'h40] = 32'hDEADBEEF;
    set_data(0, 1, 0, 0, 32'h100, 0);
    ren_cnt = 0; low_cnt = 0; served_idx = -1;
    for (int i = 0; i < 6; i++) begin
      ram_ready = (i == 3);
      cycle();
      if (ramREN) ren_cnt++;
      if (dwait[0] == 1'b0) begin
        low_cnt++; served_idx = i;
        check("rd_data", dload[WW-1:0], 32'hDEADBEEF);
        set_data(0, 0, 0, 0, 32'h100, 0);
      end
    end
    check("rd_ren_cycles", ren_cnt, 3);
    check("rd_wait_pulses", low_cnt, 1);
    check("rd_latency", served_idx, 3);

    // Instruction contention, RAM always ready
    ram_ready = 1;
    do_reset();
    iREN = 2'b11; ngrant = 0; overlap = 0;
    for (int i = 0; i < 40 && ngrant < 4; i++) begin
      cycle();
      if (iwait == 2'b00) overlap++;
      else if (iwait != 2'b11) begin order[ngrant] = iwait[0] ? 1 : 0; ngrant++; end
    end
    iREN = 0;
    cycle();
    check("cont_grants", ngrant, 4);
    check("cont_overlap", overlap, 0);
    for (int k = 0; k < 4; k++) check("cont_order", order[k], k % 2);

    // Data before instruction inside a core
    do_reset();
    set_data(0, 1, 0, 0, 32'h104, 0); iREN[0] = 1; iaddr[AW-1:0] = 32'h300;
    served = 0;
    for (int i = 0; i < 20 && !served; i++) begin
      cycle();
      if (dwait != 2'b11 || iwait != 2'b11) begin
        served = 1;
        check("data_first_d", dwait, 2'b10);
        check("data_first_i", iwait, 2'b11);
      end
    end
    check("data_first_served", served, 1);
    set_data(0, 0, 0, 0, 32'h104, 0); iREN = 0;
    cycle();

    // LL/SC pass on core 1, then a second SC fails (link consumed)
    do_data(1, 1, 0, 1, 32'h200, 0, load, served, saw_wen);
    check("ll1_served", served, 1);
    do_data(1, 0, 1, 1, 32'h200, 32'h5, load, served, saw_wen);
    check("sc1_served", served, 1);
    check("sc1_result", load, 1);
    check("sc1_wen", saw_wen, 1);
    check("sc1_ram", env_mem[8'h80], 32'h5);
    do_data(1, 0, 1, 1, 32'h200, 32'h6, load, served, saw_wen);
    check("sc1b_result", load, 0);
    check("sc1b_wen", saw_wen, 0);

    // SC fails after the other core stores to the linked word
    do_data(0, 1, 0, 1, 32'h300, 0, load, served, saw_wen);
    do_data(1, 0, 1, 0, 32'h300, 32'h77, load, served, saw_wen);
    check("sw_int_served", served, 1);
    set_data(0, 0, 1, 1, 32'h300, 32'h9);
    cycle();
    check("scf_dwait", dwait[0], 0);
    check("scf_result", dload[WW-1:0], 0);
    check("scf_wen", ramWEN, 0);
    set_data(0, 0, 0, 0, 32'h300, 0);
    cycle();

    // Reset during the second BUSY cycle of a store
    ram_ready = 0; low_cnt = 0;
    set_data(0, 0, 1, 0, 32'h104, 32'hABCD);
    cycle(); if (dwait != 2'b11) low_cnt++;
    check("mid_wen1", ramWEN, 1);
    cycle(); if (dwait != 2'b11) low_cnt++;
    RST = 1;
    cycle(); if (dwait != 2'b11) low_cnt++;
    check("mid_wen_after_rst", ramWEN, 0);
    RST = 0; set_data(0, 0, 0, 0, 32'h104, 0);
    cycle(); if (dwait != 2'b11) low_cnt++;
    check("mid_no_wait_pulse", low_cnt, 0);
    ram_ready = 1;
    do_data(0, 1, 0, 1, 32'h100, 0, load, served, saw_wen);
    do_data(0, 0, 1, 1, 32'h100, 32'h1234, load, served, saw_wen);
    check("mid_sc_result", load, 1);
    check("mid_sc_wen", saw_wen, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!(dREN[c] | dWEN[c]) && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0: set_data(c, 1, 0, 0, pool[$urandom_range(0, 3)], $urandom);
            1: set_data(c, 0, 1, 0, pool[$urandom_range(0, 3)], $urandom);
            2: set_data(c, 1, 0, 1, pool[$urandom_range(0, 3)], $urandom);
            default: set_data(c, 0, 1, 1, pool[$urandom_range(0, 3)], $urandom);
          endcase
        end
        if (!iREN[c] && $urandom_range(0, 2) == 0) begin
          iREN[c] = 1; iaddr[c*AW +: AW] = pool[$urandom_range(0, 3)];
        end
      end
      ram_ready = ($urandom_range(0, 3) != 0);
      RST = ($urandom_range(0, 199) == 0);
      cycle();
      if (m_resp) begin
        if (m_isdata) set_data(m_core, 0, 0, 0, daddr[m_core*AW +: AW], 0);
        else iREN[m_core] = 0;
      end
    end
    RST = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
